// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
`timescale 1ns/1ps
package uart_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int CLKS_PER_BIT_DEF = 868;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset to RST_VAL so the output is defined before the line settles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, one-cycle
// rx_valid / frame_err pulses. Returns to IDLE at mid stop bit so a start
// edge half a bit later is still caught.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  BIT_END  = CW'(CLKS_PER_BIT - 1);

    logic            rx_s;
    logic            rx_prev;
    rx_state_e       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic [7:0]      rx_data_n;
    logic            rx_valid_n, frame_err_n;

    // Idle line is high, so the synchronizer resets to 1
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and registered output pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_prev   <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            rx_prev   <= rx_s;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
        end
    end

    // Next-state logic; the counter only runs in timed states and is cleared on every transition
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_s)
                    state_n = START;
            end

            START: begin
                if (cnt == HALF_END) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end else begin
                        state_n   = IDLE;   // too short to be a start bit
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n            = '0;
                    shreg_n[bit_idx] = rx_s;
                    bit_idx_n        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        rx_data_n  = shreg;
                        rx_valid_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            WAIT_HIGH: begin
                // a held-low line (break) stays here, giving one frame_err only
                cnt_n = '0;
                if (rx_s)
                    state_n = IDLE;
            end

            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three instances (two at 868 clk/bit, one at 16).
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB    = 868;
    localparam int CPB_F  = 16;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = CPB * CLK_NS;
    localparam int EXP_LAT = 8246 + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     [3];
    logic       rx_line [3];
    logic [7:0] dat     [3];
    logic       vld     [3];
    logic       fe      [3];

    uart_rx #(.CLKS_PER_BIT(CPB)) u_a (
        .clk(clk), .reset(rst[0]), .rx(rx_line[0]),
        .rx_data(dat[0]), .rx_valid(vld[0]), .frame_err(fe[0]));
    uart_rx #(.CLKS_PER_BIT(CPB)) u_b (
        .clk(clk), .reset(rst[1]), .rx(rx_line[1]),
        .rx_data(dat[1]), .rx_valid(vld[1]), .frame_err(fe[1]));
    uart_rx #(.CLKS_PER_BIT(CPB_F)) u_c (
        .clk(clk), .reset(rst[2]), .rx(rx_line[2]),
        .rx_data(dat[2]), .rx_valid(vld[2]), .frame_err(fe[2]));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vcnt [3] = '{0, 0, 0};
    int fcnt [3] = '{0, 0, 0};
    int vcyc [3] = '{0, 0, 0};
    int both = 0;
    logic [7:0] q0 [$];
    logic [7:0] q2 [$];

    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i]) begin
                vcnt[i] <= vcnt[i] + 1;
                vcyc[i] <= cyc;
            end
            if (fe[i]) fcnt[i] <= fcnt[i] + 1;
            if (vld[i] && fe[i]) both <= both + 1;
        end
        if (vld[0]) q0.push_back(dat[0]);
        if (vld[2]) q2.push_back(dat[2]);
    end

    task automatic drive_frame(input int i, input logic [9:0] frame, input int bit_ns);
        for (int k = 0; k < 10; k++) begin
            rx_line[i] = frame[k];
            #(bit_ns);
        end
        rx_line[i] = 1'b1;
    endtask

    task automatic send_byte(input int i, input logic [7:0] b, input int bit_ns);
        drive_frame(i, {1'b1, b, 1'b0}, bit_ns);
    endtask

    task automatic test_reset();
        rx_line = '{1'b1, 1'b1, 1'b1};
        rst     = '{1'b1, 1'b1, 1'b1};
        #23;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (vld[i] !== 1'b0 || fe[i] !== 1'b0 || dat[i] !== 8'h00) begin
                fails++;
                $display("FAIL reset_outs[%0d]: got vld=%b fe=%b data=%h want 0 0 00", i, vld[i], fe[i], dat[i]);
            end
        end
        tests++;
        if (u_b.state !== IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d want %0d", u_b.state, IDLE);
        end
        @(negedge clk);
        rst = '{1'b0, 1'b0, 1'b0};
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int v0, f0, t0, lat;
        v0 = vcnt[1]; f0 = fcnt[1];
        @(posedge clk); #2;
        t0 = cyc;
        send_byte(1, 8'hAA, BIT_NS);
        repeat (20) @(negedge clk);
        lat = vcyc[1] - t0;
        tests++;
        if (vcnt[1] - v0 !== 1) begin
            fails++; $display("FAIL single_count: got %0d want 1", vcnt[1] - v0);
        end
        tests++;
        if (dat[1] !== 8'hAA) begin
            fails++; $display("FAIL single_data: got %h want aa", dat[1]);
        end
        tests++;
        if (lat < EXP_LAT - CPB || lat > EXP_LAT + CPB) begin
            fails++; $display("FAIL single_latency: got %0d want %0d +/- %0d", lat, EXP_LAT, CPB);
        end
        tests++;
        if (fcnt[1] !== f0) begin
            fails++; $display("FAIL single_ferr: got %0d want %0d", fcnt[1], f0);
        end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = vcnt[1]; f0 = fcnt[1];
        rx_line[1] = 1'b0;
        #(300 * CLK_NS);
        rx_line[1] = 1'b1;
        repeat (1000) @(negedge clk);
        tests++;
        if (vcnt[1] !== v0 || fcnt[1] !== f0) begin
            fails++; $display("FAIL glitch_pulses: got vld=%0d fe=%0d want 0 0", vcnt[1] - v0, fcnt[1] - f0);
        end
        tests++;
        if (u_b.state !== IDLE) begin
            fails++; $display("FAIL glitch_state: got %0d want %0d", u_b.state, IDLE);
        end
        send_byte(1, 8'h55, BIT_NS);
        repeat (20) @(negedge clk);
        tests++;
        if (vcnt[1] - v0 !== 1 || dat[1] !== 8'h55) begin
            fails++; $display("FAIL glitch_next: got cnt=%0d data=%h want 1 55", vcnt[1] - v0, dat[1]);
        end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        v0 = vcnt[1]; f0 = fcnt[1];
        drive_frame(1, {1'b0, 8'h3C, 1'b0}, BIT_NS);
        repeat (20) @(negedge clk);
        tests++;
        if (fcnt[1] - f0 !== 1) begin
            fails++; $display("FAIL ferr_count: got %0d want 1", fcnt[1] - f0);
        end
        tests++;
        if (vcnt[1] !== v0) begin
            fails++; $display("FAIL ferr_valid: got %0d want 0", vcnt[1] - v0);
        end
        tests++;
        if (dat[1] !== 8'h55) begin
            fails++; $display("FAIL ferr_data_held: got %h want 55", dat[1]);
        end
        send_byte(1, 8'h01, BIT_NS);
        repeat (20) @(negedge clk);
        tests++;
        if (vcnt[1] - v0 !== 1 || dat[1] !== 8'h01 || fcnt[1] - f0 !== 1) begin
            fails++; $display("FAIL ferr_next: got cnt=%0d data=%h fe=%0d want 1 01 1", vcnt[1] - v0, dat[1], fcnt[1] - f0);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        v0 = vcnt[1];
        // 0xF0: start, four low data bits, then reset halfway through bit 4
        rx_line[1] = 1'b0;
        #(5 * BIT_NS);
        rx_line[1] = 1'b1;
        #(BIT_NS / 2);
        rst[1] = 1'b1;
        #50;
        tests++;
        if (dat[1] !== 8'h00 || vld[1] !== 1'b0 || fe[1] !== 1'b0) begin
            fails++; $display("FAIL rstmid_clear: got data=%h vld=%b fe=%b want 00 0 0", dat[1], vld[1], fe[1]);
        end
        rst[1] = 1'b0;
        #(BIT_NS / 2 - 50 + 4 * BIT_NS);
        repeat (20) @(negedge clk);
        tests++;
        if (vcnt[1] !== v0) begin
            fails++; $display("FAIL rstmid_no_valid: got %0d want 0", vcnt[1] - v0);
        end
        send_byte(1, 8'h0F, BIT_NS);
        repeat (20) @(negedge clk);
        tests++;
        if (vcnt[1] - v0 !== 1 || dat[1] !== 8'h0F) begin
            fails++; $display("FAIL rstmid_next: got cnt=%0d data=%h want 1 0f", vcnt[1] - v0, dat[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [7];
        bytes = '{8'hAA, 8'h01, 8'h00, 8'h00, 8'hA7, 8'hC5, 8'h55};
        for (int k = 0; k < 7; k++) send_byte(0, bytes[k], BIT_NS);
        repeat (20) @(negedge clk);
        tests++;
        if (q0.size() !== 7) begin
            fails++; $display("FAIL b2b_count: got %0d want 7", q0.size());
        end
        for (int k = 0; k < 7; k++) begin
            tests++;
            if (k >= q0.size() || q0[k] !== bytes[k]) begin
                fails++;
                $display("FAIL b2b_byte[%0d]: got %h want %h", k, (k < q0.size()) ? q0[k] : 8'hxx, bytes[k]);
            end
        end
        tests++;
        if (fcnt[0] !== 0) begin
            fails++; $display("FAIL b2b_ferr: got %0d want 0", fcnt[0]);
        end
    endtask

    task automatic test_baud_err();
        logic [7:0] exp [4];
        exp = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        send_byte(2, 8'h00, 163);
        #500;
        send_byte(2, 8'hFF, 157);
        #500;
        send_byte(2, 8'h00, 157);
        send_byte(2, 8'hFF, 163);
        repeat (20) @(negedge clk);
        tests++;
        if (q2.size() !== 4) begin
            fails++; $display("FAIL baud_count: got %0d want 4", q2.size());
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (k >= q2.size() || q2[k] !== exp[k]) begin
                fails++;
                $display("FAIL baud_byte[%0d]: got %h want %h", k, (k < q2.size()) ? q2[k] : 8'hxx, exp[k]);
            end
        end
        tests++;
        if (fcnt[2] !== 0) begin
            fails++; $display("FAIL baud_ferr: got %0d want 0", fcnt[2]);
        end
    endtask

    initial begin
        test_reset();
        fork
            test_back_to_back();
            begin
                test_single();
                test_glitch();
                test_frame_err();
                test_reset_mid();
            end
        join
        test_baud_err();
        tests++;
        if (both !== 0) begin
            fails++; $display("FAIL valid_and_ferr_same_cycle: got %0d want 0", both);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per bit (100 MHz / 115200 baud); legal range 16..65535.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state advances on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rx, input, 1, the asynchronous serial line: idle high, 8N1, LSB first.
REQ-005 SHALL have port rx_data, output, 8, the last correctly framed byte.
REQ-006 SHALL have port rx_valid, output, 1, a one-cycle pulse marking rx_data as new; there is no ready/backpressure.
REQ-007 SHALL have port frame_err, output, 1, a one-cycle pulse when the stop bit is sampled low.

Function
REQ-008 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value, rx_s (2-cycle latency).
REQ-009 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-010 IDLE: a high-to-low transition on rx_s SHALL load the bit counter with 0 and enter START.
REQ-011 START: at count CLKS_PER_BIT/2-1 (integer division), SHALL re-sample rx_s.
  - Low: clear the counter, clear the bit index, enter DATA.
  - High: treat as a glitch and return to IDLE with no output pulse.
REQ-012 DATA: at each count CLKS_PER_BIT-1, SHALL shift rx_s into bit position bit_idx, increment bit_idx and clear the counter.
  - After bit_idx 7 is sampled, enter STOP.
REQ-013 STOP: at count CLKS_PER_BIT-1 (mid stop bit):
  - rx_s high: load rx_data with the assembled byte, pulse rx_valid for exactly one cycle, enter IDLE.
  - rx_s low: pulse frame_err for one cycle, leave rx_data unchanged, enter WAIT_HIGH.
REQ-014 WAIT_HIGH: SHALL hold until rx_s is high, then enter IDLE; a line held low (break) SHALL produce exactly one frame_err and no rx_valid.
REQ-015 Returning to IDLE at mid stop bit SHALL allow a start edge arriving half a bit later (back-to-back bytes) to be caught with no byte lost.
REQ-016 rx_valid and frame_err SHALL never be asserted in the same cycle.
REQ-017 Latency: rx_valid SHALL assert 9.5 bit times (±1 bit count) plus 3 clk after the falling edge of the start bit on rx.
REQ-018 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap; it is cleared on every state change.

Reset
REQ-019 While reset is high, the block SHALL asynchronously clear state to IDLE and clear the counter, bit_idx, rx_data, rx_valid and frame_err to 0, and set both synchronizer flops to 1 (idle line).
REQ-020 Reset asserted mid-byte SHALL discard the partial byte; after release, the block SHALL wait for a fresh falling edge before receiving.

Structure
REQ-021 State encoding (3-bit enum) and the default CLKS_PER_BIT constant SHALL live in the shared uart_pkg package.
REQ-022 The synchronizer SHALL be a separate sub-module, sync_2ff, with the same clk/reset ports and a reset value parameter, set to 1 here.
REQ-023 The outputs SHALL connect directly to the packet parser's rx_data/rx_valid inputs, with no glue logic.

Verification (CLKS_PER_BIT=868 unless noted)
REQ-024 Single byte 0xAA, ideal timing -> one rx_valid pulse, rx_data=0xAA, 8246±868+3 clk after the start edge, frame_err stays 0.
REQ-025 Back-to-back stream AA 01 00 00 A7 C5 55, no idle gap -> seven rx_valid pulses carrying exactly those bytes in order.
REQ-026 Low glitch of 300 clk on idle rx -> no rx_valid, no frame_err, state back in IDLE; next byte 0x55 is received correctly.
REQ-027 Byte 0x3C with stop bit forced low, then line high -> one frame_err pulse, no rx_valid, rx_data keeps its previous value; following byte 0x01 is received.
REQ-028 Reset pulse during data bit 4 of 0xF0, released mid-byte -> no rx_valid for that byte; next full byte 0x0F is received correctly.
REQ-029 CLKS_PER_BIT=16 with a sender running ±2% baud error, bytes 0x00 and 0xFF -> both received correctly with no frame_err.
